seg7_scan_driver: RTL

Parametrised time-multiplexed seven-segment display driver for N digits. It replaces the fixed four-digit scan loop in the top level. It adds:
- a load-strobed shadow register, so the display never shows a mixed value,
- leading-zero blanking,
- per-digit blinking and decimal points,
- anode dead time against ghosting,
- a frame tick.

It sits between the SoC result/cycle-counter muxing and the board digit/segment pins.

---
 rtl/seg7_scan_driver.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit seven-segment driver with shadow load,
// leading-zero blanking, per-digit blink, anode dead time and frame tick.
module seg7_scan_driver #(
  parameter int NUM_DIGITS       = 4,
  parameter int SCAN_PERIOD      = 120000,
  parameter int BLINK_DIV        = 100,
  parameter bit ANODE_ACTIVE_LOW = 1'b1,
  parameter bit SEG_ACTIVE_LOW   = 1'b0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  input  logic                    blank_lz,
  input  logic [NUM_DIGITS-1:0]   blink_en,
  output logic [NUM_DIGITS-1:0]   anodes,
  output logic [6:0]              segments,
  output logic                    dp,
  output logic                    frame_tick
);

  localparam int TW = $clog2(SCAN_PERIOD);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(SCAN_PERIOD - 1);
  localparam logic [TW-1:0] T_DEAD = TW'(1);
  localparam logic [IW-1:0] D_LAST = IW'(NUM_DIGITS - 1);
  localparam logic [BW-1:0] B_LAST = BW'(BLINK_DIV - 1);

  logic [TW-1:0]           timer_q, timer_d;
  logic [IW-1:0]           digit_q, digit_d;
  logic [IW-1:0]           slot_q, slot_d;
  logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
  logic [NUM_DIGITS-1:0]   sdp_q, sdp_d;
  logic [BW-1:0]           bcnt_q, bcnt_d;
  logic                    bphase_q, bphase_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic                    ftick_q, ftick_d;

  logic       wrap;
  logic       frame_end;
  logic       slot_start;
  logic [3:0] nib;
  logic       nib_dp;
  logic       nib_blink;
  logic       upper_zero;
  logic       blank;
  logic [6:0] pat;

  function automatic logic [6:0] hex7(input logic [3:0] h);
    logic [6:0] p;
    p = 7'b0000000;
    unique case (h)
      4'h0: p = 7'b1111110;
      4'h1: p = 7'b0110000;
      4'h2: p = 7'b1101101;
      4'h3: p = 7'b1111001;
      4'h4: p = 7'b0110011;
      4'h5: p = 7'b1011011;
      4'h6: p = 7'b1011111;
      4'h7: p = 7'b1110000;
      4'h8: p = 7'b1111111;
      4'h9: p = 7'b1111011;
      4'hA: p = 7'b1110111;
      4'hB: p = 7'b0011111;
      4'hC: p = 7'b1001110;
      4'hD: p = 7'b0111101;
      4'hE: p = 7'b1001111;
      4'hF: p = 7'b1000111;
    endcase
    return p;
  endfunction

  always_comb begin
    shadow_d = load ? data_in : shadow_q;
    sdp_d    = load ? dp_in : sdp_q;

    wrap      = (timer_q == T_LAST);
    frame_end = wrap && (digit_q == D_LAST);
    timer_d   = wrap ? '0 : timer_q + TW'(1);
    digit_d   = digit_q;
    if (wrap) begin
      digit_d = (digit_q == D_LAST) ? '0 : digit_q + IW'(1);
    end

    bcnt_d   = bcnt_q;
    bphase_d = bphase_q;
    if (frame_end) begin
      if (bcnt_q == B_LAST) begin
        bcnt_d   = '0;
        bphase_d = ~bphase_q;
      end else begin
        bcnt_d = bcnt_q + BW'(1);
      end
    end

    nib        = 4'h0;
    nib_dp     = 1'b0;
    nib_blink  = 1'b0;
    upper_zero = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (IW'(i) == digit_q) begin
        nib       = shadow_q[4*i +: 4];
        nib_dp    = sdp_q[i];
        nib_blink = blink_en[i];
      end
      if (IW'(i) >= digit_q && shadow_q[4*i +: 4] != 4'h0) begin
        upper_zero = 1'b0;
      end
    end

    blank = (blank_lz && digit_q != '0 && upper_zero)
          || (bphase_q && nib_blink);
    pat   = hex7(nib);

    // Pattern is latched once per slot so a load never splits a slot.
    slot_start = (timer_q == '0);
    slot_d     = slot_start ? digit_q : slot_q;
    seg_d      = seg_q;
    dp_d       = dp_q;
    if (slot_start) begin
      seg_d = blank ? 7'b0000000 : pat;
      dp_d  = blank ? 1'b0 : nib_dp;
    end

    an_d = '0;
    if (timer_d != T_DEAD) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        an_d[i] = (IW'(i) == slot_d);
      end
    end

    ftick_d = (timer_d == T_LAST) && (digit_d == D_LAST);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer_q  <= '0;
      digit_q  <= '0;
      slot_q   <= '0;
      shadow_q <= '0;
      sdp_q    <= '0;
      bcnt_q   <= '0;
      bphase_q <= 1'b0;
      an_q     <= '0;
      seg_q    <= '0;
      dp_q     <= 1'b0;
      ftick_q  <= 1'b0;
    end else begin
      timer_q  <= timer_d;
      digit_q  <= digit_d;
      slot_q   <= slot_d;
      shadow_q <= shadow_d;
      sdp_q    <= sdp_d;
      bcnt_q   <= bcnt_d;
      bphase_q <= bphase_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
      ftick_q  <= ftick_d;
    end
  end

  assign anodes     = ANODE_ACTIVE_LOW ? ~an_q : an_q;
  assign segments   = SEG_ACTIVE_LOW ? ~seg_q : seg_q;
  assign dp         = SEG_ACTIVE_LOW ? ~dp_q : dp_q;
  assign frame_tick = ftick_q;

endmodule
